demux_l2_sched: RTL

Dispatch scheduler in front of the level-2 1:2 byte demux, in the clk_2f domain. Accepts an 8-bit byte stream with valid/ready handshake and drives the demux selectorL2/valid/data inputs. Enforces strict lane alternation (byte k → lane k mod 2, lane 0 first) so the unstriping side stays aligned. Stalls on per-lane back-pressure from the downstream lane FIFOs using a one-entry hold register, so no byte is lost or reordered.

---
 rtl/demux_l2_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/demux_l2_sched.sv
// ---------------------------------------------------------------------------
// demux_l2_sched
//
// Dispatch scheduler in front of the level-2 1:2 byte demux, clk_2f domain.
// Takes a valid/ready byte stream and hands one byte per cycle to the demux.
// Bytes alternate strictly between lanes (lane 0 first) so the unstriping side
// stays aligned. When the lane due next reports full, the byte waits in a
// one-entry hold register. No byte is lost, reordered or sent to the wrong lane.
//
// Ports:
//   clk_2f      in   sole clock, rising edge
//   reset_L     in   synchronous active-low reset
//   valid_in    in   upstream byte valid
//   data_in     in   upstream byte [DATA_W]
//   ready_in    out  scheduler can accept a byte this cycle (combinational)
//   lane_full0  in   lane 0 FIFO cannot take a byte this cycle
//   lane_full1  in   lane 1 FIFO cannot take a byte this cycle
//   realign     in   synchronous lane realignment / flush request
//   selectorL2  out  demux lane select (0 -> out0, 1 -> out1)
//   valid_out   out  byte valid into the demux
//   data_out    out  byte into the demux [DATA_W]
//   next_lane   out  lane the next dispatched byte will use
//
// Optional feature (macro DEMUX_L2_STATS_EN):
//   cnt_lane0   out  bytes dispatched to lane 0 [CNT_W], wraps
//   cnt_lane1   out  bytes dispatched to lane 1 [CNT_W], wraps
//   cnt_stall   out  cycles spent in STALL [CNT_W], wraps
// ---------------------------------------------------------------------------
module demux_l2_sched #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_in,
  input  logic              lane_full0,
  input  logic              lane_full1,
  input  logic              realign,
  output logic              selectorL2,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              next_lane
`ifdef DEMUX_L2_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_lane0,
  output logic [CNT_W-1:0]  cnt_lane1,
  output logic [CNT_W-1:0]  cnt_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STRIPE = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic              next_lane_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              valid_d;
  logic [DATA_W-1:0] data_d;
  logic              sel_d;
  logic              accept;
  logic              due_lane_full;

  // Only the lane that is due next matters; the other lane's full flag is
  // deliberately ignored so the scheduler never skips a lane.
  assign due_lane_full = next_lane ? lane_full1 : lane_full0;

  // While a byte sits in the hold register the upstream must wait.
  assign ready_in = reset_L & ~realign & (state != STALL);
  assign accept   = valid_in & ready_in;

  // Next-state and next-output logic. data_out and selectorL2 keep their
  // last values on idle cycles; only valid_out drops back to 0.
  always_comb begin
    state_d     = state;
    next_lane_d = next_lane;
    hold_d      = hold_q;
    valid_d     = 1'b0;
    data_d      = data_out;
    sel_d       = selectorL2;

    if (realign) begin
      state_d     = IDLE;
      next_lane_d = 1'b0;
      hold_d      = '0;
    end else begin
      case (state)
        STALL: begin
          if (!due_lane_full) begin
            valid_d     = 1'b1;
            data_d      = hold_q;
            sel_d       = next_lane;
            next_lane_d = ~next_lane;
            state_d     = STRIPE;
          end
        end
        default: begin
          if (accept) begin
            if (!due_lane_full) begin
              valid_d     = 1'b1;
              data_d      = data_in;
              sel_d       = next_lane;
              next_lane_d = ~next_lane;
              state_d     = STRIPE;
            end else begin
              hold_d  = data_in;
              state_d = STALL;
            end
          end
        end
      endcase
    end
  end

  // State and registered demux-side outputs.
  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      state      <= IDLE;
      next_lane  <= 1'b0;
      hold_q     <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      selectorL2 <= 1'b0;
    end else begin
      state      <= state_d;
      next_lane  <= next_lane_d;
      hold_q     <= hold_d;
      valid_out  <= valid_d;
      data_out   <= data_d;
      selectorL2 <= sel_d;
    end
  end

`ifdef DEMUX_L2_STATS_EN
  // Statistics counters move on the same edge as the dispatch or stall cycle
  // they count, and wrap naturally at 2^CNT_W.
  always_ff @(posedge clk_2f) begin
    if (!reset_L || realign) begin
      cnt_lane0 <= '0;
      cnt_lane1 <= '0;
      cnt_stall <= '0;
    end else begin
      if (valid_d && !sel_d) cnt_lane0 <= cnt_lane0 + 1'b1;
      if (valid_d && sel_d)  cnt_lane1 <= cnt_lane1 + 1'b1;
      if (state == STALL)    cnt_stall <= cnt_stall + 1'b1;
    end
  end
`endif

endmodule
